// File: rtl/xn_seq_div.sv
// xn_seq_div: sequential restoring divider, 2W-bit dividend by W-bit divisor.
// Produces one quotient bit per clock (MSB first) behind valid/ready handshakes.
// A zero divisor short-circuits straight to a flagged all-ones result.
module xn_seq_div #(
   parameter int unsigned W = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] dividend,
   input  logic [W-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] quotient,
   output logic [W-1:0]   remainder,
   output logic           div_by_zero
);

   localparam int unsigned CW = $clog2(2*W+1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic [2*W-1:0] shf_q,   shf_d;
   logic [W-1:0]   part_q,  part_d;
   logic [W-1:0]   dvs_q,   dvs_d;
   logic [2*W-1:0] quo_q,   quo_d;
   logic [W-1:0]   rem_q,   rem_d;
   logic           dbz_q,   dbz_d;
   logic           ov_q,    ov_d;

   logic [W:0]     trial;
   logic           take;
   logic [W-1:0]   diff;
   logic [W-1:0]   part_step;
   logic [2*W-1:0] quo_step;

   // One restoring step. The shifted-in dividend bits are consumed from the top
   // of shf_q while quotient bits enter at the bottom, so after 2W steps shf_q
   // holds the quotient. The stored partial stays below the divisor, so it fits
   // in W bits; only the trial value needs the extra bit.
   always_comb begin
      trial     = {part_q, shf_q[2*W-1]};
      take      = (trial >= {1'b0, dvs_q});
      diff      = trial[W-1:0] - dvs_q;
      part_step = take ? diff : trial[W-1:0];
      quo_step  = {shf_q[2*W-2:0], take};
   end

   // Next-state and datapath control for IDLE / BUSY / DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shf_d   = shf_q;
      part_d  = part_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      ov_d    = ov_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               shf_d  = dividend;
               dvs_d  = divisor;
               part_d = '0;
               cnt_d  = CW'(2*W);
               if (divisor == '0) begin
                  state_d = S_DONE;
                  quo_d   = '1;
                  rem_d   = dividend[W-1:0];
                  dbz_d   = 1'b1;
                  ov_d    = 1'b1;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            shf_d  = quo_step;
            part_d = part_step;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               quo_d   = quo_step;
               rem_d   = part_step;
               dbz_d   = 1'b0;
               ov_d    = 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
               ov_d    = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            ov_d    = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset; reset overrides any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shf_q   <= '0;
         part_q  <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shf_q   <= shf_d;
         part_q  <= part_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ov_q    <= ov_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE) && !rst;
   assign out_valid   = ov_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_xn_seq_div.sv
// tb_xn_seq_div: directed table, exhaustive sweep, round trip, random ops and
// multi-cycle corner sequences for xn_seq_div at W=2, plus a W=4 instance.
module tb_xn_seq_div;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, div_by_zero;
   logic [3:0] dividend, quotient;
   logic [1:0] divisor, remainder;

   logic       in_valid4, in_ready4, out_valid4, out_ready4, div_by_zero4;
   logic [7:0] dividend4, quotient4;
   logic [3:0] divisor4, remainder4;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   xn_seq_div #(.W(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
      .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   xn_seq_div #(.W(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .dividend(dividend4), .divisor(divisor4), .out_valid(out_valid4),
      .out_ready(out_ready4), .quotient(quotient4), .remainder(remainder4),
      .div_by_zero(div_by_zero4)
   );

   typedef struct {
      logic [3:0] a;
      logic [1:0] b;
      logic [3:0] q;
      logic [1:0] r;
      logic       z;
      int         lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: plain integer division with the zero-divisor rule.
   task automatic model2(input logic [3:0] a, input logic [1:0] b,
                         output logic [3:0] q, output logic [1:0] r, output logic z);
      if (b == 0) begin
         q = 4'd15; r = a[1:0]; z = 1'b1;
      end else begin
         q = 4'(a / b); r = 2'(a % b); z = 1'b0;
      end
   endtask

   // One W=2 operation: waits for in_ready, accepts, optionally pokes in_valid
   // while busy, holds off out_ready for 'hold' cycles checking stability,
   // then completes the handshake. lat = rising edges after the accept edge.
   task automatic run2(input logic [3:0] a, input logic [1:0] b, input int hold,
                       input bit poke, output logic [3:0] q, output logic [1:0] r,
                       output logic z, output int lat);
      int guard = 0;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      chk("in_ready_before_accept", in_ready, 1);
      in_valid = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      in_valid = poke; dividend = 4'($urandom); divisor = 2'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      chk("out_valid_seen", out_valid, 1);
      q = quotient; r = remainder; z = div_by_zero;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", out_valid, 1);
         chk("hold_quotient", quotient, q);
         chk("hold_remainder", remainder, r);
         chk("hold_dbz", div_by_zero, z);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_hs_out_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
      chk("post_hs_quotient_kept", quotient, q);
      chk("post_hs_remainder_kept", remainder, r);
   endtask

   task automatic run4(input logic [7:0] a, input logic [3:0] b,
                       output logic [7:0] q, output logic [3:0] r, output int lat);
      int guard = 0;
      while (!in_ready4 && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      in_valid4 = 1'b1; dividend4 = a; divisor4 = b;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      q = quotient4; r = remainder4;
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
   endtask

   vec_t tbl[8];

   initial begin
      logic [3:0] q, eq;
      logic [1:0] r, er;
      logic       z, ez;
      logic [7:0] q4;
      logic [3:0] r4;
      int         lat;
      int         acc[$];

      tbl[0] = '{4'd9,  2'd2, 4'd4,  2'd1, 1'b0, 4};
      tbl[1] = '{4'd7,  2'd0, 4'd15, 2'd3, 1'b1, 0};
      tbl[2] = '{4'd6,  2'd3, 4'd2,  2'd0, 1'b0, 4};
      tbl[3] = '{4'd15, 2'd3, 4'd5,  2'd0, 1'b0, 4};
      tbl[4] = '{4'd14, 2'd3, 4'd4,  2'd2, 1'b0, 4};
      tbl[5] = '{4'd0,  2'd1, 4'd0,  2'd0, 1'b0, 4};
      tbl[6] = '{4'd15, 2'd1, 4'd15, 2'd0, 1'b0, 4};
      tbl[7] = '{4'd15, 2'd2, 4'd7,  2'd1, 1'b0, 4};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; dividend4 = '0; divisor4 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready_low", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_quotient", quotient, 0);
      chk("reset_remainder", remainder, 0);
      chk("reset_dbz", div_by_zero, 0);

      // Directed table (includes 9/2, 7/0 followed by 6/3).
      foreach (tbl[i]) begin
         run2(tbl[i].a, tbl[i].b, 0, 1'b0, q, r, z, lat);
         chk("tbl_quotient", q, tbl[i].q);
         chk("tbl_remainder", r, tbl[i].r);
         chk("tbl_dbz", z, tbl[i].z);
         chk("tbl_latency", lat, tbl[i].lat);
      end

      // Exhaustive nonzero-divisor sweep.
      for (int a = 0; a < 16; a++) begin
         for (int b = 1; b < 4; b++) begin
            run2(4'(a), 2'(b), 0, 1'b0, q, r, z, lat);
            chk("sweep_quotient", q, a / b);
            chk("sweep_remainder", r, a % b);
         end
      end

      // Round trip from 2-bit multiplier products.
      for (int a = 0; a < 4; a++) begin
         for (int b = 1; b < 4; b++) begin
            run2(4'(a * b), 2'(b), 0, 1'b0, q, r, z, lat);
            chk("roundtrip_quotient", q, a);
            chk("roundtrip_remainder", r, 0);
         end
      end

      // Backpressure with in_valid pokes while busy/done.
      run2(4'd15, 2'd3, 5, 1'b1, q, r, z, lat);
      chk("bp_quotient", q, 5);
      chk("bp_remainder", r, 0);
      chk("bp_dbz", z, 0);

      // Reset mid-operation: abort 14/3 after two BUSY steps.
      in_valid = 1'b1; dividend = 4'd14; divisor = 2'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_quotient", quotient, 0);
      chk("midrst_remainder", remainder, 0);
      chk("midrst_dbz", div_by_zero, 0);
      repeat (6) begin
         @(posedge clk); #1;
         chk("midrst_no_result", out_valid, 0);
      end
      run2(4'd14, 2'd3, 0, 1'b0, q, r, z, lat);
      chk("after_rst_quotient", q, 4);
      chk("after_rst_remainder", r, 2);

      // Throughput with in_valid and out_ready held high.
      in_valid = 1'b1; out_ready = 1'b1; dividend = 4'd6; divisor = 2'd3;
      for (int c = 0; c < 20; c++) begin
         if (in_ready) acc.push_back(c);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("tput_accepts", (acc.size() >= 2) ? 1 : 0, 1);
      if (acc.size() >= 2) chk("tput_period", acc[1] - acc[0], 6);

      // Random operations against the model.
      for (int i = 0; i < 60; i++) begin
         logic [3:0] a;
         logic [1:0] b;
         a = 4'($urandom_range(0, 15));
         b = 2'($urandom_range(0, 3));
         model2(a, b, eq, er, ez);
         run2(a, b, $urandom_range(0, 3), 1'($urandom), q, r, z, lat);
         chk("rnd_quotient", q, eq);
         chk("rnd_remainder", r, er);
         chk("rnd_dbz", z, ez);
      end

      // W=4 instance.
      run4(8'd200, 4'd7, q4, r4, lat);
      chk("w4_200_7_quotient", q4, 28);
      chk("w4_200_7_remainder", r4, 4);
      chk("w4_latency", lat, 8);
      run4(8'd255, 4'd15, q4, r4, lat);
      chk("w4_255_15_quotient", q4, 17);
      chk("w4_255_15_remainder", r4, 0);
      for (int i = 0; i < 20; i++) begin
         logic [7:0] a;
         logic [3:0] b;
         a = 8'($urandom_range(0, 255));
         b = 4'($urandom_range(1, 15));
         run4(a, b, q4, r4, lat);
         chk("w4_rnd_quotient", q4, a / b);
         chk("w4_rnd_remainder", r4, a % b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
